// File: rtl/gcd_arb_pkg.sv
// gcd_arb_pkg
// Shared types and constants for the GCD arbiter slice.
//   arb_state_e : arbiter FSM encoding (2 bits)
//   OPND_W_DEF  : default GCD operand / result width
//   STAT_W      : width of the optional statistics counters
//   slice_off() : bit offset of a requester's packed {a,b} message
package gcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RETURN    = 2'd3
  } arb_state_e;

  localparam int OPND_W_DEF = 16;
  localparam int STAT_W     = 32;

  // Offset of requester idx's message inside the packed request bus.
  function automatic int unsigned slice_off(input int unsigned idx,
                                            input int unsigned msg_w);
    return idx * msg_w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin priority picker. Searches req_i starting at
// last_grant_i + 1 and wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   req_i         in  NUM_REQ  request vector
//   last_grant_i  in  IDX_W    index of the previous grant
//   grant_valid_o out 1        at least one request is set
//   grant_idx_o   out IDX_W    winning index (0 when grant_valid_o is 0)
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  // Rotating first-one search; k = NUM_REQ revisits last_grant itself last.
  always_comb begin
    int             cand_int;
    logic [IDX_W-1:0] cand;
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand_int      = 0;
    cand          = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_int = (int'(last_grant_i) + k) % NUM_REQ;
      cand     = cand_int[IDX_W-1:0];
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end else begin
        grant_valid_o = grant_valid_o;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter
// Shares a single non-pipelined GcdUnit between NUM_REQ requesters using
// round-robin arbitration with one transaction in flight. The owner of each
// transaction is recorded and the response is returned to that channel only.
// Optional statistics counters are enabled by defining GCD_ARB_STATS_EN;
// without it stat_done / stat_busy are tied to 0 and no counters exist.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   req_val/req_rdy/req_msg      per-requester request channel ({a,b} packed)
//   resp_val/resp_rdy/resp_msg   per-requester response, shared result bus
//   gcd_req_*/gcd_resp_*         val/rdy link to the GcdUnit
//   busy                         FSM not in IDLE
//   stat_done, stat_busy         completed transactions / busy cycles
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OPND_W  = OPND_W_DEF
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic [NUM_REQ-1:0]          req_val,
  output logic [NUM_REQ-1:0]          req_rdy,
  input  logic [NUM_REQ*2*OPND_W-1:0] req_msg,
  output logic [NUM_REQ-1:0]          resp_val,
  input  logic [NUM_REQ-1:0]          resp_rdy,
  output logic [OPND_W-1:0]           resp_msg,
  output logic                        gcd_req_val,
  input  logic                        gcd_req_rdy,
  output logic [2*OPND_W-1:0]         gcd_req_msg,
  input  logic                        gcd_resp_val,
  output logic                        gcd_resp_rdy,
  input  logic [OPND_W-1:0]           gcd_resp_msg,
  output logic                        busy,
  output logic [STAT_W-1:0]           stat_done,
  output logic [STAT_W-1:0]           stat_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int MSG_W = 2 * OPND_W;
  localparam int OFF_W = $clog2(NUM_REQ * MSG_W);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [OPND_W-1:0]  res_q, res_d;

  logic               grant_valid_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [OFF_W-1:0]   grant_off_s;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i         (req_val),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid_s),
    .grant_idx_o   (grant_idx_s)
  );

  assign grant_off_s = OFF_W'(slice_off(32'(grant_idx_s), 32'(MSG_W)));

  // State and datapath registers; last_grant starts at NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      msg_q        <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      msg_q        <= msg_d;
      res_q        <= res_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    msg_d        = msg_q;
    res_d        = res_q;
    req_rdy      = '0;
    resp_val     = '0;
    gcd_req_val  = 1'b0;
    gcd_resp_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so no request is acknowledged while reset is held.
        if (grant_valid_s && wb_rst_ni) begin
          req_rdy[grant_idx_s] = 1'b1;
          owner_d              = grant_idx_s;
          msg_d                = req_msg[grant_off_s +: MSG_W];
          state_d              = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        gcd_req_val = 1'b1;
        if (gcd_req_rdy) begin
          state_d = WAIT_RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_RESP: begin
        gcd_resp_rdy = 1'b1;
        if (gcd_resp_val) begin
          res_d   = gcd_resp_msg;
          state_d = RETURN;
        end else begin
          state_d = WAIT_RESP;
        end
      end
      RETURN: begin
        resp_val[owner_q] = 1'b1;
        // Arbitration resumes only in the following cycle (no bypass).
        if (resp_rdy[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end else begin
          state_d = RETURN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gcd_req_msg = msg_q;
  assign resp_msg    = res_q;
  assign busy        = (state_q != IDLE);

`ifdef GCD_ARB_STATS_EN
  logic              done_s;
  logic [STAT_W-1:0] stat_done_q;
  logic [STAT_W-1:0] stat_busy_q;

  assign done_s = (state_q == RETURN) && resp_rdy[owner_q];

  // Wrapping statistics counters.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      stat_done_q <= '0;
      stat_busy_q <= '0;
    end else begin
      if (done_s) begin
        stat_done_q <= stat_done_q + STAT_W'(1);
      end
      if (busy) begin
        stat_busy_q <= stat_busy_q + STAT_W'(1);
      end
    end
  end

  assign stat_done = stat_done_q;
  assign stat_busy = stat_busy_q;
`else
  assign stat_done = '0;
  assign stat_busy = '0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter
// Self-checking bench for gcd_arbiter with a behavioural GcdUnit (configurable
// latency and request stall). Expected (channel, result) pairs are queued when
// stimulus is applied and compared against observed responses.
module tb_gcd_arbiter;

  localparam int NR = 4;
  localparam int OW = 16;
  localparam int MW = 2 * OW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  req_val = '0;
  logic [NR-1:0]  req_rdy;
  logic [NR*MW-1:0] req_msg = '0;
  logic [NR-1:0]  resp_val;
  logic [NR-1:0]  resp_rdy = '1;
  logic [OW-1:0]  resp_msg;
  logic           gcd_req_val, gcd_req_rdy, gcd_resp_val, gcd_resp_rdy;
  logic [MW-1:0]  gcd_req_msg;
  logic [OW-1:0]  gcd_resp_msg;
  logic           busy;
  logic [31:0]    stat_done, stat_busy;

  always #5 clk = ~clk;

  gcd_arbiter #(.NUM_REQ(NR), .OPND_W(OW)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_msg      (req_msg),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_msg     (resp_msg),
    .gcd_req_val  (gcd_req_val),
    .gcd_req_rdy  (gcd_req_rdy),
    .gcd_req_msg  (gcd_req_msg),
    .gcd_resp_val (gcd_resp_val),
    .gcd_resp_rdy (gcd_resp_rdy),
    .gcd_resp_msg (gcd_resp_msg),
    .busy         (busy),
    .stat_done    (stat_done),
    .stat_busy    (stat_busy)
  );

  // ---------------- behavioural GcdUnit ----------------
  logic          m_busy;
  int            m_cnt;
  logic [OW-1:0] m_res;
  logic          stall = 1'b0;
  int            m_lat = 2;

  function automatic logic [OW-1:0] gcd_f(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic [OW-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  assign gcd_req_rdy  = !m_busy && !stall;
  assign gcd_resp_val = m_busy && (m_cnt == 0);
  assign gcd_resp_msg = m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (!m_busy) begin
      if (gcd_req_val && gcd_req_rdy) begin
        m_busy <= 1'b1;
        m_cnt  <= m_lat;
        m_res  <= gcd_f(gcd_req_msg[MW-1:OW], gcd_req_msg[OW-1:0]);
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end else if (gcd_resp_rdy) begin
      m_busy <= 1'b0;
    end
  end

  // ---------------- observation logs and scoreboard ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          keep_val = 1'b0;
  int            grant_log[$];
  int            resp_ch_log[$];
  logic [OW-1:0] resp_msg_log[$];
  logic [NR-1:0] resp_vec_log[$];
  logic [MW-1:0] gmsg_log[$];
  int            exp_ch_q[$];
  logic [OW-1:0] exp_res_q[$];

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    grant_log.delete(); resp_ch_log.delete(); resp_msg_log.delete();
    resp_vec_log.delete(); gmsg_log.delete();
  endtask

  task automatic set_req(input int ch, input logic [OW-1:0] a, input logic [OW-1:0] b);
    req_msg[ch*MW +: MW] = {a, b};
    req_val[ch] = 1'b1;
  endtask

  task automatic push_exp(input int ch, input logic [OW-1:0] res);
    exp_ch_q.push_back(ch);
    exp_res_q.push_back(res);
  endtask

  // One clock: sample handshakes mid-cycle, cross the edge, drop granted requests.
  task automatic step();
    logic [NR-1:0] g;
    #1;
    g = req_rdy;
    if (g != 0) grant_log.push_back(idx_of(g));
    if ((resp_val & resp_rdy) != 0) begin
      resp_ch_log.push_back(idx_of(resp_val & resp_rdy));
      resp_msg_log.push_back(resp_msg);
      resp_vec_log.push_back(resp_val);
    end
    if (gcd_req_val && gcd_req_rdy) gmsg_log.push_back(gcd_req_msg);
    @(posedge clk);
    #1;
    if (!keep_val) req_val = req_val & ~g;
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (resp_ch_log.size() < n && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_val = '0; resp_rdy = '1; stall = 1'b0;
    m_lat = 2; keep_val = 1'b0; req_msg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({req_rdy, resp_val, gcd_req_val, gcd_resp_rdy, busy} !== '0)
      $display("FAIL reset_ctrl: got %b required 0", {req_rdy, resp_val, gcd_req_val, gcd_resp_rdy, busy});
    else n_pass++;
    n_checks++;
    if (resp_msg !== '0) $display("FAIL reset_resp_msg: got %0d required 0", resp_msg);
    else n_pass++;
    n_checks++;
    if (gcd_req_msg !== '0) $display("FAIL reset_gcd_msg: got %h required 0", gcd_req_msg);
    else n_pass++;
    n_checks++;
    if (stat_done !== 32'd0 || stat_busy !== 32'd0)
      $display("FAIL reset_stats: got %0d/%0d required 0/0", stat_done, stat_busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int e_ch, a_ch; logic [OW-1:0] e_res, a_res; logic [NR-1:0] a_vec;
    clear_logs();
    push_exp(2, 16'd5);
    set_req(2, 16'd15, 16'd5);
    #1;
    n_checks++;
    if (req_rdy !== 4'b0100) $display("FAIL single_rdy: got %b required 0100", req_rdy);
    else n_pass++;
    run_until(1, 60);
    n_checks++;
    if (gmsg_log.size() != 1 || gmsg_log[0] !== {16'd15, 16'd5})
      $display("FAIL single_gcd_msg: got %p required {15,5}", gmsg_log);
    else n_pass++;
    while (exp_ch_q.size() != 0) begin
      e_ch = exp_ch_q.pop_front(); e_res = exp_res_q.pop_front();
      n_checks++;
      if (resp_ch_log.size() == 0) $display("FAIL single_resp: missing, required ch %0d res %0d", e_ch, e_res);
      else begin
        a_ch = resp_ch_log.pop_front(); a_res = resp_msg_log.pop_front(); a_vec = resp_vec_log.pop_front();
        if (a_ch !== e_ch || a_res !== e_res || a_vec !== (4'b0001 << e_ch))
          $display("FAIL single_resp: got ch %0d res %0d vec %b required ch %0d res %0d", a_ch, a_res, a_vec, e_ch, e_res);
        else n_pass++;
      end
    end
`ifdef GCD_ARB_STATS_EN
    n_checks++;
    if (stat_done !== 32'd1) $display("FAIL single_stat_done: got %0d required 1", stat_done);
    else n_pass++;
    n_checks++;
    if (stat_busy !== 32'd5) $display("FAIL single_stat_busy: got %0d required 5", stat_busy);
    else n_pass++;
`endif
  endtask

  task automatic test_all_four();
    int e_ch, a_ch; logic [OW-1:0] e_res, a_res; logic [NR-1:0] a_vec;
    do_reset();
    clear_logs();
    set_req(0, 16'd48, 16'd18); set_req(1, 16'd35, 16'd14);
    set_req(2, 16'd100, 16'd75); set_req(3, 16'd17, 16'd13);
    push_exp(0, 16'd6); push_exp(1, 16'd7); push_exp(2, 16'd25); push_exp(3, 16'd1);
    run_until(4, 200);
    n_checks++;
    if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 2 || grant_log[3] != 3)
      $display("FAIL all4_grants: got %p required 0,1,2,3", grant_log);
    else n_pass++;
    while (exp_ch_q.size() != 0) begin
      e_ch = exp_ch_q.pop_front(); e_res = exp_res_q.pop_front();
      n_checks++;
      if (resp_ch_log.size() == 0) $display("FAIL all4_resp: missing, required ch %0d res %0d", e_ch, e_res);
      else begin
        a_ch = resp_ch_log.pop_front(); a_res = resp_msg_log.pop_front(); a_vec = resp_vec_log.pop_front();
        if (a_ch !== e_ch || a_res !== e_res || a_vec !== (4'b0001 << e_ch))
          $display("FAIL all4_resp: got ch %0d res %0d vec %b required ch %0d res %0d", a_ch, a_res, a_vec, e_ch, e_res);
        else n_pass++;
      end
    end
  endtask

  task automatic test_resp_backpressure();
    int e_ch, a_ch, c; logic [OW-1:0] e_res, a_res; logic [NR-1:0] a_vec; logic hold_ok;
    clear_logs();
    resp_rdy = 4'b1101;
    set_req(1, 16'd35, 16'd14);
    push_exp(1, 16'd7); push_exp(0, 16'd6);
    c = 0;
    while (!resp_val[1] && c < 40) begin step(); c++; end
    n_checks++;
    if (resp_val[1] !== 1'b1) $display("FAIL bp_reach: resp_val got %b required bit 1 set", resp_val);
    else n_pass++;
    set_req(0, 16'd48, 16'd18);
    hold_ok = 1'b1;
    repeat (20) begin
      #1;
      if (resp_val !== 4'b0010 || resp_msg !== 16'd7 || busy !== 1'b1 || req_rdy !== 4'b0000) hold_ok = 1'b0;
      step();
    end
    n_checks++;
    if (!hold_ok) $display("FAIL bp_hold: got val %b msg %0d busy %b rdy %b required 0010/7/1/0000", resp_val, resp_msg, busy, req_rdy);
    else n_pass++;
    resp_rdy = '1;
    run_until(2, 100);
    n_checks++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 0)
      $display("FAIL bp_grants: got %p required 1,0", grant_log);
    else n_pass++;
    while (exp_ch_q.size() != 0) begin
      e_ch = exp_ch_q.pop_front(); e_res = exp_res_q.pop_front();
      n_checks++;
      if (resp_ch_log.size() == 0) $display("FAIL bp_resp: missing, required ch %0d res %0d", e_ch, e_res);
      else begin
        a_ch = resp_ch_log.pop_front(); a_res = resp_msg_log.pop_front(); a_vec = resp_vec_log.pop_front();
        if (a_ch !== e_ch || a_res !== e_res || a_vec !== (4'b0001 << e_ch))
          $display("FAIL bp_resp: got ch %0d res %0d vec %b required ch %0d res %0d", a_ch, a_res, a_vec, e_ch, e_res);
        else n_pass++;
      end
    end
  endtask

  task automatic test_gcd_backpressure();
    int e_ch, a_ch; logic [OW-1:0] e_res, a_res; logic [NR-1:0] a_vec; logic stall_ok;
    clear_logs();
    stall = 1'b1;
    set_req(3, 16'd100, 16'd75);
    push_exp(3, 16'd25);
    step();
    stall_ok = 1'b1;
    repeat (5) begin
      #1;
      if (gcd_req_val !== 1'b1 || gcd_req_msg !== {16'd100, 16'd75}) stall_ok = 1'b0;
      step();
    end
    n_checks++;
    if (!stall_ok || resp_ch_log.size() != 0 || gmsg_log.size() != 0)
      $display("FAIL gbp_hold: got val %b msg %h required 1 and %h", gcd_req_val, gcd_req_msg, {16'd100, 16'd75});
    else n_pass++;
    stall = 1'b0;
    run_until(1, 60);
    n_checks++;
    if (gmsg_log.size() != 1 || gmsg_log[0] !== {16'd100, 16'd75})
      $display("FAIL gbp_issue: got %p required one {100,75}", gmsg_log);
    else n_pass++;
    while (exp_ch_q.size() != 0) begin
      e_ch = exp_ch_q.pop_front(); e_res = exp_res_q.pop_front();
      n_checks++;
      if (resp_ch_log.size() == 0) $display("FAIL gbp_resp: missing, required ch %0d res %0d", e_ch, e_res);
      else begin
        a_ch = resp_ch_log.pop_front(); a_res = resp_msg_log.pop_front(); a_vec = resp_vec_log.pop_front();
        if (a_ch !== e_ch || a_res !== e_res || a_vec !== (4'b0001 << e_ch))
          $display("FAIL gbp_resp: got ch %0d res %0d vec %b required ch %0d res %0d", a_ch, a_res, a_vec, e_ch, e_res);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int e_ch, a_ch, c; logic [OW-1:0] e_res, a_res; logic [NR-1:0] a_vec;
    clear_logs();
    m_lat = 10;
    set_req(0, 16'd48, 16'd18);
    c = 0;
    while (!gcd_resp_rdy && c < 20) begin step(); c++; end
    n_checks++;
    if (gcd_resp_rdy !== 1'b1) $display("FAIL rmid_reach: gcd_resp_rdy got %b required 1", gcd_resp_rdy);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_rdy, resp_val, gcd_req_val, gcd_resp_rdy, busy} !== '0 || resp_msg !== '0 || gcd_req_msg !== '0)
      $display("FAIL rmid_outputs: got ctrl %b msg %0d gmsg %h required all 0",
               {req_rdy, resp_val, gcd_req_val, gcd_resp_rdy, busy}, resp_msg, gcd_req_msg);
    else n_pass++;
    m_lat = 2;
    set_req(0, 16'd48, 16'd18);
    set_req(3, 16'd17, 16'd13);
    #1;
    n_checks++;
    if (req_rdy !== 4'b0000) $display("FAIL rmid_rdy_in_reset: got %b required 0000", req_rdy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    push_exp(0, 16'd6); push_exp(3, 16'd1);
    run_until(2, 100);
    repeat (10) step();
    n_checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3)
      $display("FAIL rmid_grants: got %p required 0,3", grant_log);
    else n_pass++;
    while (exp_ch_q.size() != 0) begin
      e_ch = exp_ch_q.pop_front(); e_res = exp_res_q.pop_front();
      n_checks++;
      if (resp_ch_log.size() == 0) $display("FAIL rmid_resp: missing, required ch %0d res %0d", e_ch, e_res);
      else begin
        a_ch = resp_ch_log.pop_front(); a_res = resp_msg_log.pop_front(); a_vec = resp_vec_log.pop_front();
        if (a_ch !== e_ch || a_res !== e_res || a_vec !== (4'b0001 << e_ch))
          $display("FAIL rmid_resp: got ch %0d res %0d vec %b required ch %0d res %0d", a_ch, a_res, a_vec, e_ch, e_res);
        else n_pass++;
      end
    end
    n_checks++;
    if (resp_ch_log.size() != 0) $display("FAIL rmid_extra: got %0d extra responses required 0", resp_ch_log.size());
    else n_pass++;
  endtask

  task automatic test_fairness();
    int e_ch, a_ch; logic [OW-1:0] e_res, a_res; logic [NR-1:0] a_vec; logic ok;
    int exp_g[6];
    exp_g = '{1, 3, 1, 3, 1, 3};
    clear_logs();
    keep_val = 1'b1;
    set_req(1, 16'd35, 16'd14);
    set_req(3, 16'd17, 16'd13);
    for (int i = 0; i < 6; i++) begin
      if (exp_g[i] == 1) push_exp(1, 16'd7);
      else push_exp(3, 16'd1);
    end
    run_until(6, 200);
    req_val = '0;
    keep_val = 1'b0;
    repeat (4) step();
    ok = (grant_log.size() == 6);
    for (int i = 0; i < 6; i++) if (ok && grant_log[i] != exp_g[i]) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL fair_grants: got %p required 1,3,1,3,1,3", grant_log);
    else n_pass++;
    while (exp_ch_q.size() != 0) begin
      e_ch = exp_ch_q.pop_front(); e_res = exp_res_q.pop_front();
      n_checks++;
      if (resp_ch_log.size() == 0) $display("FAIL fair_resp: missing, required ch %0d res %0d", e_ch, e_res);
      else begin
        a_ch = resp_ch_log.pop_front(); a_res = resp_msg_log.pop_front(); a_vec = resp_vec_log.pop_front();
        if (a_ch !== e_ch || a_res !== e_res || a_vec !== (4'b0001 << e_ch))
          $display("FAIL fair_resp: got ch %0d res %0d vec %b required ch %0d res %0d", a_ch, a_res, a_vec, e_ch, e_res);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_resp_backpressure();
    test_gcd_backpressure();
    test_reset_mid();
    test_fairness();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
